// File: rtl/bus_initiator.sv
// bus_initiator: single-outstanding register-bus initiator.
// Accepts one command, drives the peripheral select phase until the
// peripheral acknowledges or the wait budget runs out, then returns a
// one-cycle response. It only goes back to idle once the acknowledge has dropped.
module bus_initiator #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_sysclk,
  input  logic        i_sysrst,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic        i_cmd_wr,
  input  logic [3:0]  i_cmd_addr,
  input  logic [15:0] i_cmd_data,
  output logic        o_bus_select,
  output logic        o_bus_wr,
  output logic [3:0]  o_reg_addr,
  output logic [15:0] o_bus_data,
  input  logic [15:0] i_bus_data,
  input  logic        i_bus_ack,
  output logic        o_rsp_valid,
  output logic [15:0] o_rsp_data,
  output logic        o_rsp_err
);

  // Wait budget in counter units; the counter starts at 0 in the first
  // select cycle, so the last allowed cycle is the one where cnt+1 hits it.
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [15:0] wait_cnt_r, wait_cnt_nxt_s;

  logic        accept_s, ack_hit_s, timeout_s;

  logic        cmd_ready_r,  cmd_ready_s;
  logic        bus_select_r, bus_select_s;
  logic        bus_wr_r,     bus_wr_s;
  logic [3:0]  reg_addr_r,   reg_addr_s;
  logic [15:0] bus_data_r,   bus_data_s;
  logic        rsp_valid_r,  rsp_valid_s;
  logic [15:0] rsp_data_r,   rsp_data_s;
  logic        rsp_err_r,    rsp_err_s;

  // Transaction events: command handshake, acknowledge, and budget expiry (ack wins).
  always_comb begin
    accept_s  = (state_r == ST_IDLE) && i_cmd_valid;
    ack_hit_s = (state_r == ST_REQ) && i_bus_ack;
    timeout_s = (state_r == ST_REQ) && !i_bus_ack &&
                ((wait_cnt_r + 16'd1) == TIMEOUT_LIM);
  end

  // Next-state logic for IDLE -> REQ -> RELEASE -> IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_REQ;
        else          state_nxt_s = ST_IDLE;
      end
      ST_REQ: begin
        if (ack_hit_s || timeout_s) state_nxt_s = ST_RELEASE;
        else                        state_nxt_s = ST_REQ;
      end
      ST_RELEASE: begin
        if (i_bus_ack) state_nxt_s = ST_RELEASE;
        else           state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and the wait counter.
  always_comb begin
    cmd_ready_s  = (state_nxt_s == ST_IDLE);
    bus_select_s = (state_nxt_s == ST_REQ);
    rsp_valid_s  = ack_hit_s || timeout_s;

    if (accept_s) begin
      bus_wr_s       = i_cmd_wr;
      reg_addr_s     = i_cmd_addr;
      bus_data_s     = i_cmd_wr ? i_cmd_data : 16'h0000;
      wait_cnt_nxt_s = 16'd0;
    end else begin
      bus_wr_s       = (state_nxt_s == ST_REQ) ? bus_wr_r : 1'b0;
      reg_addr_s     = reg_addr_r;
      bus_data_s     = bus_data_r;
      if ((state_r == ST_REQ) && !i_bus_ack && !timeout_s) begin
        wait_cnt_nxt_s = wait_cnt_r + 16'd1;
      end else begin
        wait_cnt_nxt_s = wait_cnt_r;
      end
    end

    // bus_wr_r still carries the command direction while in REQ.
    if (ack_hit_s) begin
      rsp_data_s = bus_wr_r ? 16'h0000 : i_bus_data;
      rsp_err_s  = 1'b0;
    end else if (timeout_s) begin
      rsp_data_s = 16'h0000;
      rsp_err_s  = 1'b1;
    end else begin
      rsp_data_s = rsp_data_r;
      rsp_err_s  = rsp_err_r;
    end
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      state_r      <= ST_IDLE;
      wait_cnt_r   <= 16'd0;
      cmd_ready_r  <= 1'b1;
      bus_select_r <= 1'b0;
      bus_wr_r     <= 1'b0;
      reg_addr_r   <= 4'd0;
      bus_data_r   <= 16'h0000;
      rsp_valid_r  <= 1'b0;
      rsp_data_r   <= 16'h0000;
      rsp_err_r    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      wait_cnt_r   <= wait_cnt_nxt_s;
      cmd_ready_r  <= cmd_ready_s;
      bus_select_r <= bus_select_s;
      bus_wr_r     <= bus_wr_s;
      reg_addr_r   <= reg_addr_s;
      bus_data_r   <= bus_data_s;
      rsp_valid_r  <= rsp_valid_s;
      rsp_data_r   <= rsp_data_s;
      rsp_err_r    <= rsp_err_s;
    end
  end

  assign o_cmd_ready  = cmd_ready_r;
  assign o_bus_select = bus_select_r;
  assign o_bus_wr     = bus_wr_r;
  assign o_reg_addr   = reg_addr_r;
  assign o_bus_data   = bus_data_r;
  assign o_rsp_valid  = rsp_valid_r;
  assign o_rsp_data   = rsp_data_r;
  assign o_rsp_err    = rsp_err_r;

endmodule

// File: tb/tb_bus_initiator.sv
// Self-checking bench for bus_initiator: directed scenarios plus randomized
// transactions, each compared against an expected timeline derived from the
// command, the ack arrival cycle and the wait budget.
module tb_bus_initiator;

  localparam int TMO = 8;

  logic        i_sysclk = 1'b0;
  logic        i_sysrst;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_wr;
  logic [3:0]  i_cmd_addr;
  logic [15:0] i_cmd_data;
  logic        o_bus_select;
  logic        o_bus_wr;
  logic [3:0]  o_reg_addr;
  logic [15:0] o_bus_data;
  logic [15:0] i_bus_data;
  logic        i_bus_ack;
  logic        o_rsp_valid;
  logic [15:0] o_rsp_data;
  logic        o_rsp_err;

  int checks = 0;
  int errors = 0;

  bus_initiator #(.TIMEOUT_CYCLES(TMO)) dut (
    .i_sysclk    (i_sysclk),
    .i_sysrst    (i_sysrst),
    .i_cmd_valid (i_cmd_valid),
    .o_cmd_ready (o_cmd_ready),
    .i_cmd_wr    (i_cmd_wr),
    .i_cmd_addr  (i_cmd_addr),
    .i_cmd_data  (i_cmd_data),
    .o_bus_select(o_bus_select),
    .o_bus_wr    (o_bus_wr),
    .o_reg_addr  (o_reg_addr),
    .o_bus_data  (o_bus_data),
    .i_bus_data  (i_bus_data),
    .i_bus_ack   (i_bus_ack),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_err   (o_rsp_err)
  );

  always #5 i_sysclk = ~i_sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Command-side activity while busy: either a held follow-up command or random noise.
  task automatic side(input bit hn, input logic nwr, input logic [3:0] naddr, input logic [15:0] ndata);
    if (hn) begin
      i_cmd_valid = 1'b1; i_cmd_wr = nwr; i_cmd_addr = naddr; i_cmd_data = ndata;
    end else begin
      i_cmd_valid = 1'($urandom_range(0, 1));
      i_cmd_wr    = 1'($urandom_range(0, 1));
      i_cmd_addr  = 4'($urandom);
      i_cmd_data  = 16'($urandom);
    end
  endtask

  task automatic step();
    @(posedge i_sysclk);
    @(negedge i_sysclk);
  endtask

  // One complete transaction; called at a negedge with the DUT idle.
  // ack_cycle: REQ cycle (1-based) on which ack is sampled; 0 or > TMO means none.
  // hold: extra cycles ack stays high after the acknowledged edge.
  task automatic run_txn(input logic wr, input logic [3:0] addr, input logic [15:0] data,
                         input int ack_cycle, input int hold, input logic [15:0] rdata,
                         input bit hn, input logic nwr, input logic [3:0] naddr,
                         input logic [15:0] ndata);
    bit          tmo;
    int          n_req;
    logic [15:0] exp_bd, exp_rd;
    tmo    = (ack_cycle < 1) || (ack_cycle > TMO);
    n_req  = tmo ? TMO : ack_cycle;
    exp_bd = wr ? data : 16'h0000;
    exp_rd = (tmo || wr) ? 16'h0000 : rdata;

    chk("idle_ready", {31'd0, o_cmd_ready}, 32'd1);
    chk("idle_select", {31'd0, o_bus_select}, 32'd0);
    i_cmd_valid = 1'b1; i_cmd_wr = wr; i_cmd_addr = addr; i_cmd_data = data;
    i_bus_ack = 1'b0;
    step();
    side(hn, nwr, naddr, ndata);

    for (int i = 1; i <= n_req; i++) begin
      chk("req_select", {31'd0, o_bus_select}, 32'd1);
      chk("req_wr", {31'd0, o_bus_wr}, {31'd0, wr});
      chk("req_addr", {28'd0, o_reg_addr}, {28'd0, addr});
      chk("req_data", {16'd0, o_bus_data}, {16'd0, exp_bd});
      chk("req_ready", {31'd0, o_cmd_ready}, 32'd0);
      chk("req_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
      i_bus_ack  = (i == ack_cycle);
      i_bus_data = (i == ack_cycle) ? rdata : 16'($urandom);
      step();
      side(hn, nwr, naddr, ndata);
    end

    chk("rsp_select", {31'd0, o_bus_select}, 32'd0);
    chk("rsp_wr", {31'd0, o_bus_wr}, 32'd0);
    chk("rsp_valid", {31'd0, o_rsp_valid}, 32'd1);
    chk("rsp_err", {31'd0, o_rsp_err}, {31'd0, tmo});
    chk("rsp_data", {16'd0, o_rsp_data}, {16'd0, exp_rd});
    chk("rsp_ready", {31'd0, o_cmd_ready}, 32'd0);
    i_bus_ack  = (hold > 0);
    i_bus_data = 16'($urandom);

    for (int j = 1; j <= hold; j++) begin
      step();
      side(hn, nwr, naddr, ndata);
      chk("rel_ready", {31'd0, o_cmd_ready}, 32'd0);
      chk("rel_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
      chk("rel_select", {31'd0, o_bus_select}, 32'd0);
      chk("rel_rsp_data", {16'd0, o_rsp_data}, {16'd0, exp_rd});
      i_bus_ack = (j < hold);
    end

    step();
    if (!hn) i_cmd_valid = 1'b0;
    chk("end_ready", {31'd0, o_cmd_ready}, 32'd1);
    chk("end_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("end_rsp_err", {31'd0, o_rsp_err}, {31'd0, tmo});
    chk("end_rsp_data", {16'd0, o_rsp_data}, {16'd0, exp_rd});
  endtask

  initial begin
    logic        rwr;
    logic [3:0]  raddr;
    logic [15:0] rdat, rrd;
    int          rack, rhold;

    i_sysrst = 1'b1; i_cmd_valid = 1'b0; i_cmd_wr = 1'b0; i_cmd_addr = 4'd0;
    i_cmd_data = 16'h0000; i_bus_data = 16'h0000; i_bus_ack = 1'b0;
    repeat (3) @(posedge i_sysclk);
    @(negedge i_sysclk);
    chk("rst_ready", {31'd0, o_cmd_ready}, 32'd1);
    chk("rst_select", {31'd0, o_bus_select}, 32'd0);
    chk("rst_wr", {31'd0, o_bus_wr}, 32'd0);
    chk("rst_addr", {28'd0, o_reg_addr}, 32'd0);
    chk("rst_bus_data", {16'd0, o_bus_data}, 32'd0);
    chk("rst_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("rst_rsp_data", {16'd0, o_rsp_data}, 32'd0);
    chk("rst_rsp_err", {31'd0, o_rsp_err}, 32'd0);
    i_sysrst = 1'b0;
    step();

    // Write, ack on the third REQ cycle.
    run_txn(1'b1, 4'h1, 16'h007F, 3, 0, 16'hDEAD, 1'b0, 1'b0, 4'h0, 16'h0000);
    // Read, immediate ack with 0x0F0F (minimum latency).
    run_txn(1'b0, 4'h4, 16'hBEEF, 1, 0, 16'h0F0F, 1'b0, 1'b0, 4'h0, 16'h0000);
    // No ack: timeout after TMO cycles.
    run_txn(1'b1, 4'h9, 16'h1234, 0, 0, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000);
    // Ack exactly on the last budgeted cycle: ack wins.
    run_txn(1'b0, 4'hA, 16'h0000, TMO, 0, 16'hA5C3, 1'b0, 1'b0, 4'h0, 16'h0000);
    // Ack held high for five cycles.
    run_txn(1'b0, 4'h2, 16'h0000, 1, 4, 16'h5555, 1'b0, 1'b0, 4'h0, 16'h0000);
    // Two commands with valid held high: second accepted only once idle.
    run_txn(1'b1, 4'h3, 16'h1111, 2, 0, 16'h0000, 1'b1, 1'b1, 4'hC, 16'h2222);
    run_txn(1'b1, 4'hC, 16'h2222, 2, 1, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000);

    // Reset in the middle of REQ aborts without a response.
    i_cmd_valid = 1'b1; i_cmd_wr = 1'b1; i_cmd_addr = 4'h6; i_cmd_data = 16'h6666;
    step();
    i_cmd_valid = 1'b0;
    chk("abort_select_pre", {31'd0, o_bus_select}, 32'd1);
    step();
    i_sysrst = 1'b1;
    step();
    i_sysrst = 1'b0;
    chk("abort_select", {31'd0, o_bus_select}, 32'd0);
    chk("abort_ready", {31'd0, o_cmd_ready}, 32'd1);
    chk("abort_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    chk("abort_addr", {28'd0, o_reg_addr}, 32'd0);
    step();
    chk("abort_rsp_valid2", {31'd0, o_rsp_valid}, 32'd0);
    run_txn(1'b1, 4'h7, 16'h7777, 2, 0, 16'h0000, 1'b0, 1'b0, 4'h0, 16'h0000);

    // Randomized transactions against the expected timeline.
    for (int k = 0; k < 40; k++) begin
      rwr   = 1'($urandom_range(0, 1));
      raddr = 4'($urandom);
      rdat  = 16'($urandom);
      rrd   = 16'($urandom);
      rack  = int'($urandom_range(0, TMO + 3));
      rhold = int'($urandom_range(0, 3));
      run_txn(rwr, raddr, rdat, rack, ((rack < 1) || (rack > TMO)) ? 0 : rhold, rrd,
              1'b0, 1'b0, 4'h0, 16'h0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
